// File: rtl/bm_output_sink.sv
// Purpose: consume a BondMachine output port, queue accepted values, and show each on the LEDs for a fixed hold time.
// Latency: the received pulse follows the push by 1 cycle; led updates 1 cycle after a pop; each value is held HOLD_CYCLES cycles.
// Backpressure: while the FIFO is full, valid is left unacknowledged (no drop) and the sticky stalled flag is set.
module bm_output_sink #(
    parameter int DATA_W      = 1,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset_signal,
    input  logic [DATA_W-1:0]        bm_o,
    input  logic                     bm_o_valid,
    output logic                     bm_o_received,
    output logic [7:0]               led,
    output logic                     led_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     stalled
);

    // Pointer index width; pointers carry one extra wrap bit above it.
    localparam int AW = $clog2(DEPTH);
    // Hold counter width; a one-cycle hold still needs a 1-bit counter.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [AW:0]   PTR_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic {
        CAP_IDLE,
        CAP_ACK
    } cap_state_t;

    typedef enum logic {
        SHOW_IDLE,
        SHOW
    } disp_state_t;

    cap_state_t          cap_state;
    disp_state_t         disp_state;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [CW-1:0]       hold_cnt;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [7:0]          head_ext;

    // Full/empty come straight from the current pointers, so a pop on the
    // same edge never frees a slot for a push attempted on that edge.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Occupancy is the pointer distance; the wrap bit keeps DEPTH distinct from 0.
    assign fifo_count = wr_ptr - rd_ptr;

    // A value is taken only from IDLE; the ACK cycle ignores valid because
    // the processor is still holding the value it just handed over.
    assign push = (cap_state == CAP_IDLE) && bm_o_valid && !full;

    // The display pops when it is idle, or when the current hold window is
    // on its last cycle, so consecutive values show with no gap.
    assign pop = !empty && ((disp_state == SHOW_IDLE) || (hold_cnt == '0));

    // Zero-extend the FIFO head to the LED width.
    always_comb begin
        head_ext = '0;
        head_ext[DATA_W-1:0] = mem[rd_ptr[AW-1:0]];
    end

    // FIFO storage: written on an accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bm_o;
        end
    end

    // Capture FSM: accept, acknowledge for one cycle, then look again.
    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) begin
            cap_state     <= CAP_IDLE;
            bm_o_received <= 1'b0;
            stalled       <= 1'b0;
            wr_ptr        <= '0;
        end else begin
            case (cap_state)
                CAP_IDLE: begin
                    bm_o_received <= 1'b0;
                    if (bm_o_valid) begin
                        if (!full) begin
                            wr_ptr        <= wr_ptr + PTR_ONE;
                            bm_o_received <= 1'b1;
                            cap_state     <= CAP_ACK;
                        end else begin
                            stalled <= 1'b1;
                        end
                    end
                end
                CAP_ACK: begin
                    bm_o_received <= 1'b0;
                    cap_state     <= CAP_IDLE;
                end
                default: begin
                    bm_o_received <= 1'b0;
                    cap_state     <= CAP_IDLE;
                end
            endcase
        end
    end

    // Display FSM: load a value, hold it for HOLD_CYCLES, chain or go idle.
    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) begin
            disp_state <= SHOW_IDLE;
            led        <= 8'h00;
            led_valid  <= 1'b0;
            hold_cnt   <= '0;
            rd_ptr     <= '0;
        end else begin
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                led        <= head_ext;
                led_valid  <= 1'b1;
                hold_cnt   <= HOLD_LAST;
                disp_state <= SHOW;
            end else if (disp_state == SHOW) begin
                if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - CNT_ONE;
                end else begin
                    // Nothing queued: blank the valid flag but leave the last value on led.
                    led_valid  <= 1'b0;
                    disp_state <= SHOW_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bm_output_sink.sv
module tb_bm_output_sink;

    localparam int DATA_W = 1;
    localparam int DEPTH  = 4;
    localparam int HOLD   = 8;

    logic                   clk = 1'b0;
    logic                   reset_signal = 1'b1;
    logic [DATA_W-1:0]      bm_o = '0;
    logic                   bm_o_valid = 1'b0;
    logic                   bm_o_received;
    logic [7:0]             led;
    logic                   led_valid;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   stalled;

    bm_output_sink #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk           (clk),
        .reset_signal  (reset_signal),
        .bm_o          (bm_o),
        .bm_o_valid    (bm_o_valid),
        .bm_o_received (bm_o_received),
        .led           (led),
        .led_valid     (led_valid),
        .fifo_count    (fifo_count),
        .stalled       (stalled)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: values in issue order, popped when a display window opens.
    logic [7:0] exp_q[$];

    // Reference bookkeeping for the monitor.
    int         accepted = 0;
    int         windows = 0;
    int         run_len = 0;
    int         last_run = 0;
    int         max_count = 0;
    logic       prev_rcv = 1'b0;
    logic [7:0] cur_led = 8'h00;
    logic [7:0] e;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_signal) begin
            accepted  = 0;
            windows   = 0;
            run_len   = 0;
            max_count = 0;
            prev_rcv  = 1'b0;
            exp_q.delete();
        end else begin
            if (bm_o_received) begin
                chk("rcv_pulse_width", int'(prev_rcv), 0);
                accepted++;
            end
            prev_rcv = bm_o_received;
            if (led_valid) begin
                if (run_len % HOLD == 0) begin
                    windows++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL display_unexpected: got led=%02h, expected no new window", led);
                    end else begin
                        e = exp_q.pop_front();
                        chk("display_value", int'(led), int'(e));
                    end
                    cur_led = led;
                end else begin
                    chk("display_stable", int'(led), int'(cur_led));
                end
                run_len++;
            end else if (run_len != 0) begin
                chk("hold_length", run_len % HOLD, 0);
                chk("led_kept", int'(led), int'(cur_led));
                last_run = run_len;
                run_len  = 0;
            end
            // Occupancy must equal values acknowledged minus values displayed.
            chk("count_model", int'(fifo_count), accepted - windows);
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        end
    end

    // Processor model: present a value, hold valid until received is seen.
    task automatic send(input logic [DATA_W-1:0] v, input bit keep, output int waits);
        logic [7:0] ev;
        ev = '0;
        ev[DATA_W-1:0] = v;
        bm_o       = v;
        bm_o_valid = 1'b1;
        exp_q.push_back(ev);
        waits = 0;
        forever begin
            @(negedge clk);
            waits++;
            if (bm_o_received) break;
            if (waits >= 200) begin
                n_vec++;
                n_err++;
                $display("FAIL ack_timeout: got no received after %0d cycles, expected one", waits);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) bm_o_valid = 1'b0;
    endtask

    // Wait until every issued value has been displayed and the display is idle.
    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || led_valid) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        #1;
        chk("drain_done", int'(exp_q.size() == 0 && !led_valid), 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_received"}, int'(bm_o_received), 0);
        chk({tag, "_led"}, int'(led), 0);
        chk({tag, "_led_valid"}, int'(led_valid), 0);
        chk({tag, "_count"}, int'(fifo_count), 0);
        chk({tag, "_stalled"}, int'(stalled), 0);
    endtask

    initial begin
        #500000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: got no end of test, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int w;
        int gap;
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] vals [7];

        repeat (3) @(negedge clk);
        reset_signal = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Reset in the middle of the acknowledge cycle.
        @(posedge clk);
        #1;
        bm_o       = 1'b1;
        bm_o_valid = 1'b1;
        w = 0;
        while (!bm_o_received && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("t1_ack_wait", w, 2);
        #2;
        reset_signal = 1'b1;
        bm_o_valid   = 1'b0;
        #1;
        chk("t1_async_drop", int'(bm_o_received), 0);
        repeat (2) @(negedge clk);
        #1;
        reset_signal = 1'b0;
        @(negedge clk);
        check_all_zero("t1_after");

        // Single value.
        @(posedge clk);
        #1;
        send(1'b1, 1'b0, w);
        chk("t2_ack_wait", w, 2);
        drain();
        chk("t2_led_kept", int'(led), 8'h01);
        chk("t2_run_len", last_run, HOLD);
        chk("t2_stalled", int'(stalled), 0);

        // Back-to-back 1,0,1 with valid never dropping.
        @(posedge clk);
        #1;
        send(1'b1, 1'b1, w);
        chk("t3_ack_wait0", w, 2);
        send(1'b0, 1'b1, w);
        chk("t3_ack_wait1", w, 2);
        send(1'b1, 1'b0, w);
        chk("t3_ack_wait2", w, 2);
        drain();
        chk("t3_run_len", last_run, 3 * HOLD);
        chk("t3_led_kept", int'(led), 8'h01);
        chk("t3_stalled", int'(stalled), 0);

        // Burst into a full FIFO; the 7th value is blocked on the pop edge
        // and acknowledged one edge later.
        @(negedge clk);
        reset_signal = 1'b1;
        @(negedge clk);
        reset_signal = 1'b0;
        @(posedge clk);
        #1;
        vals[0] = 1'b1; vals[1] = 1'b0; vals[2] = 1'b1; vals[3] = 1'b1;
        vals[4] = 1'b0; vals[5] = 1'b0; vals[6] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(vals[i], (i < 6), w);
            chk("t4_ack_wait", w, (i == 6) ? 8 : 2);
        end
        drain();
        chk("t4_peak_count", max_count, DEPTH);
        chk("t4_stalled", int'(stalled), 1);
        chk("t4_count_end", int'(fifo_count), 0);

        // Random stream with random gaps through the wrapping pointers.
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            v   = DATA_W'($urandom);
            gap = $urandom_range(0, 3);
            send(v, (gap == 0), w);
            if (gap != 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        bm_o_valid = 1'b0;
        drain();
        chk("t6_count_end", int'(fifo_count), 0);
        chk("t6_led_valid", int'(led_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
